// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and parity polarity
// common to the RX deserializer and the TX serializer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

  // 1 = odd parity: data bits plus parity bit carry an odd number of ones.
  localparam logic PARITY_ODD = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; RST_VAL sets the
// reset value so an idle-high line does not look like activity out of reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: mid-bit sampling of a synchronized line,
// LSB-first data, optional odd parity, one stop bit, break detection.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned OVERSAMPLING = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_tick,
  input  logic                  i_rxd,
  input  logic                  i_parity,
  output logic [WORD_WIDTH-1:0] o_dout,
  output logic                  o_valid,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_break,
  output logic                  o_active
);

  localparam int unsigned TW = $clog2(OVERSAMPLING);
  localparam int unsigned BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [TW-1:0] HALF_RELOAD = TW'(OVERSAMPLING/2 - 1);
  localparam logic [TW-1:0] FULL_RELOAD = TW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(WORD_WIDTH - 1);

  rx_state_e             state;
  logic [TW-1:0]         tick_ctr;
  logic [BW-1:0]         bit_ctr;
  logic [WORD_WIDTH-1:0] shift_reg;
  logic                  par_en;
  logic                  par_bit;
  logic                  rxd_s;
  logic                  mid;
  logic                  par_bad;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_rxd_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .d       (i_rxd),
    .q       (rxd_s)
  );

  assign mid      = i_tick && (tick_ctr == '0);
  assign par_bad  = ((^shift_reg) ^ par_bit) != PARITY_ODD;
  assign o_active = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      tick_ctr     <= '0;
      bit_ctr      <= '0;
      shift_reg    <= '0;
      par_en       <= 1'b0;
      par_bit      <= 1'b0;
      o_dout       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      // Counting only advances on ticks; mid marks the centre of a bit.
      if (i_tick && state != IDLE && state != WAIT_HIGH && tick_ctr != '0)
        tick_ctr <= tick_ctr - 1'b1;
      case (state)
        IDLE: if (i_tick && !rxd_s) begin
          tick_ctr <= HALF_RELOAD;
          par_en   <= i_parity;
          state    <= START;
        end
        START: if (mid) begin
          if (!rxd_s) begin
            tick_ctr <= FULL_RELOAD;
            bit_ctr  <= '0;
            state    <= DATA;
          end else begin
            state <= IDLE;
          end
        end
        DATA: if (mid) begin
          shift_reg <= {rxd_s, shift_reg[WORD_WIDTH-1:1]};
          tick_ctr  <= FULL_RELOAD;
          if (bit_ctr == LAST_BIT) state <= par_en ? PARITY : STOP;
          else                     bit_ctr <= bit_ctr + 1'b1;
        end
        PARITY: if (mid) begin
          par_bit  <= rxd_s;
          tick_ctr <= FULL_RELOAD;
          state    <= STOP;
        end
        STOP: if (mid) begin
          // Leave at mid-stop so the next start edge is caught with drift margin.
          o_valid      <= 1'b1;
          o_dout       <= shift_reg;
          o_parity_err <= par_en & par_bad;
          o_frame_err  <= !rxd_s;
          o_break      <= !rxd_s && (shift_reg == '0) && (!par_en || !par_bit);
          state        <= rxd_s ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: if (rxd_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: 16x oversampling, tick every 4 clocks.
module tb_uart_rx_deser;

  localparam int BIT_CLKS = 64;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_tick = 1'b0;
  logic       i_rxd = 1'b1;
  logic       i_parity = 1'b0;
  logic [7:0] o_dout;
  logic       o_valid, o_parity_err, o_frame_err, o_break, o_active;

  int n_vec = 0;
  int n_err = 0;
  int vcnt  = 0;
  int base;

  uart_rx_deser #(.WORD_WIDTH(8), .OVERSAMPLING(16)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_tick       (i_tick),
    .i_rxd        (i_rxd),
    .i_parity     (i_parity),
    .o_dout       (o_dout),
    .o_valid      (o_valid),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_break      (o_break),
    .o_active     (o_active)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    int tc;
    tc = 0;
    forever begin
      @(negedge i_clk);
      i_tick = (tc == 3);
      tc = (tc + 1) % 4;
    end
  end

  always @(negedge i_clk) if (o_valid) vcnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic b, input int clks);
    i_rxd = b;
    repeat (clks) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par,
                            input logic pbit, input logic stop);
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold(d[i], BIT_CLKS);
    if (has_par) hold(pbit, BIT_CLKS);
    hold(stop, BIT_CLKS);
  endtask

  task automatic chk_word(input string tag, input logic [7:0] d, input logic pe,
                          input logic fe, input logic brk);
    chk({tag, "_cnt"}, vcnt - base, 1);
    chk({tag, "_dout"}, o_dout, d);
    chk({tag, "_perr"}, o_parity_err, pe);
    chk({tag, "_ferr"}, o_frame_err, fe);
    chk({tag, "_brk"}, o_break, brk);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_dout", o_dout, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_flags", {o_parity_err, o_frame_err, o_break}, 0);
    chk("rst_active", o_active, 0);
    i_rst_n = 1'b1;
    hold(1'b1, 20);

    // 0xA5, no parity
    base = vcnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    chk_word("a5", 8'hA5, 0, 0, 0);
    chk("a5_active", o_active, 0);
    hold(1'b1, 40);

    // 0x3C with correct odd parity bit 1, then wrong parity bit 0
    i_parity = 1'b1;
    base = vcnt;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    chk_word("3c_ok", 8'h3C, 0, 0, 0);
    hold(1'b1, 40);
    base = vcnt;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    chk_word("3c_bad", 8'h3C, 1, 0, 0);
    i_parity = 1'b0;
    hold(1'b1, 40);

    // 5-tick glitch must be rejected from START
    base = vcnt;
    hold(1'b0, 20);
    hold(1'b1, 2 * BIT_CLKS);
    chk("glitch_cnt", vcnt - base, 0);
    chk("glitch_active", o_active, 0);

    // 0x55 with low stop bit, line released after one bit time
    base = vcnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    chk("55_wait_active", o_active, 1);
    hold(1'b1, 40);
    chk_word("55_ferr", 8'h55, 0, 1, 0);
    chk("55_active", o_active, 0);

    // break: 30 bit times low
    base = vcnt;
    hold(1'b0, 30 * BIT_CLKS);
    chk_word("brk", 8'h00, 0, 1, 1);
    chk("brk_active_low", o_active, 1);
    hold(1'b1, 8);
    chk("brk_active_rel", o_active, 0);
    hold(1'b1, 40);
    chk("brk_no_more", vcnt - base, 1);

    // back-to-back 0x01, 0xFF
    base = vcnt;
    send_frame(8'h01, 1'b0, 1'b0, 1'b1);
    chk_word("b2b_01", 8'h01, 0, 0, 0);
    base = vcnt;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    chk_word("b2b_ff", 8'hFF, 0, 0, 0);

    // reset mid-frame of 0x81
    base = vcnt;
    hold(1'b0, BIT_CLKS);
    hold(1'b1, BIT_CLKS);
    hold(1'b0, BIT_CLKS);
    i_rst_n = 1'b0;
    i_rxd = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("mrst_dout", o_dout, 0);
    chk("mrst_flags", {o_valid, o_parity_err, o_frame_err, o_break}, 0);
    chk("mrst_active", o_active, 0);
    i_rst_n = 1'b1;
    hold(1'b1, 3 * BIT_CLKS);
    chk("mrst_no_valid", vcnt - base, 0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    chk_word("post_81", 8'h81, 0, 0, 0);
    hold(1'b1, 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
